// File: rtl/sample_history.sv
// Upstream sampler for the change block: synchronizes din, samples it on a prescaled tick
// into a 3-deep history C, and qualifies that history with valid/stable/level/edge/run outputs.
module sample_history #(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    output logic [2:0]       C,
    output logic             valid,
    output logic             stable,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] run_cnt
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, FILL, TRACK} state_t;

    state_t          state;
    logic            sync1, din_s;
    logic [PW-1:0]   pcnt;
    logic [1:0]      fill;
    logic            level_d;
    logic            tick;
    logic            track_tick;
    logic [2:0]      c_next;
    logic            c_next_stable;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latches.
    always_comb begin
        tick          = en && (pcnt == PW'(PRESCALE - 1));
        c_next        = {C[1:0], din_s};
        c_next_stable = (c_next == 3'b000) || (c_next == 3'b111);
        // A tick counts as a TRACK tick both in TRACK and on the tick that completes the fill.
        track_tick    = tick && ((state == TRACK) || (fill == 2'd2));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            din_s <= 1'b0;
        end else begin
            sync1 <= din;
            din_s <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pcnt <= '0;
        else if (!en || tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            C       <= 3'b000;
            fill    <= 2'd0;
            valid   <= 1'b0;
            stable  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            run_cnt <= '0;
        end else begin
            // Edge pulses trail the level change by one cycle and are mutually exclusive.
            level_d <= level;
            rise    <= level & ~level_d;
            fall    <= ~level & level_d;

            if (!en) begin
                state   <= IDLE;
                fill    <= 2'd0;
                valid   <= 1'b0;
                stable  <= 1'b0;
                run_cnt <= '0;
            end else begin
                if (tick)
                    C <= c_next;

                unique case (state)
                    IDLE, FILL: begin
                        state <= FILL;
                        if (tick) begin
                            fill <= fill + 2'd1;
                            if (fill == 2'd2) begin
                                state <= TRACK;
                                valid <= 1'b1;
                            end
                        end
                    end
                    TRACK: state <= TRACK;
                    default: state <= IDLE;
                endcase

                if (track_tick) begin
                    stable <= c_next_stable;
                    if (!c_next_stable)
                        run_cnt <= '0;
                    else if (run_cnt != {CNT_W{1'b1}})
                        run_cnt <= run_cnt + CNT_W'(1);
                    if (c_next_stable && (c_next[0] != level))
                        level <= c_next[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_history.sv
// Directed bench for sample_history: PRESCALE=4 main instance plus a PRESCALE=1 instance.
module tb_sample_history;

    logic       clk = 1'b0;
    logic       reset, en, din, en1, din1;
    logic [2:0] C, C1;
    logic       valid, stable, level, rise, fall;
    logic       valid1, stable1, level1, rise1, fall1;
    logic [7:0] run_cnt, run_cnt1;

    int vectors = 0;
    int miscompares = 0;
    logic rise_seen, fall_seen;

    always #5 clk = ~clk;

    sample_history #(.PRESCALE(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .din(din), .C(C), .valid(valid), .stable(stable),
        .level(level), .rise(rise), .fall(fall), .run_cnt(run_cnt)
    );

    sample_history #(.PRESCALE(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .en(en1), .din(din1), .C(C1), .valid(valid1), .stable(stable1),
        .level(level1), .rise(rise1), .fall(fall1), .run_cnt(run_cnt1)
    );

    // Advance n rising edges, landing 1 time unit after the last one; records edge pulses seen.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rise_seen = rise_seen | rise;
            fall_seen = fall_seen | fall;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; din = 1'b0; en1 = 1'b0; din1 = 1'b0;
        step(2);
        if (C !== 3'b000) begin miscompares++; $display("FAIL reset_c: got %b want 000", C); end
        vectors++;
        if ({valid, stable, level, rise, fall} !== 5'b0) begin miscompares++;
            $display("FAIL reset_flags: got %b want 00000", {valid, stable, level, rise, fall}); end
        vectors++;
        if (run_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_run: got %0d want 0", run_cnt); end
        vectors++;
        if ({C1, valid1, level1} !== 5'b0) begin miscompares++;
            $display("FAIL reset_p1: got %b want 00000", {C1, valid1, level1}); end
        vectors++;
    endtask

    // Called right after an edge with reset asserted; releases reset and fills with din=1.
    task automatic test_fill(input string tag);
        reset = 1'b0; en = 1'b1; din = 1'b1; rise_seen = 1'b0;
        step(3);
        if (C !== 3'b000) begin miscompares++; $display("FAIL %s_c3: got %b want 000", tag, C); end
        vectors++;
        step(1);
        if ({C, valid} !== 4'b0010) begin miscompares++; $display("FAIL %s_e4: C,valid got %b want 0010", tag, {C, valid}); end
        vectors++;
        step(4);
        if ({C, valid} !== 4'b0110) begin miscompares++; $display("FAIL %s_e8: C,valid got %b want 0110", tag, {C, valid}); end
        vectors++;
        step(4);
        if ({C, valid, stable, level, rise} !== 7'b1111110) begin miscompares++;
            $display("FAIL %s_e12: C,valid,stable,level,rise got %b want 1111110", tag, {C, valid, stable, level, rise}); end
        vectors++;
        if (run_cnt !== 8'd1) begin miscompares++; $display("FAIL %s_run12: got %0d want 1", tag, run_cnt); end
        vectors++;
        step(1);
        if (rise !== 1'b1) begin miscompares++; $display("FAIL %s_rise13: got %b want 1", tag, rise); end
        vectors++;
        step(1);
        if ({rise, fall} !== 2'b00) begin miscompares++; $display("FAIL %s_rise14: rise,fall got %b want 00", tag, {rise, fall}); end
        vectors++;
    endtask

    // Starts at edge 14 (pcnt=2); one zero sample is captured at edge 20.
    task automatic test_glitch;
        fall_seen = 1'b0;
        din = 1'b0;
        step(4);
        din = 1'b1;
        step(2);
        if ({C, stable, level} !== 5'b11001) begin miscompares++;
            $display("FAIL glitch_e20: C,stable,level got %b want 11001", {C, stable, level}); end
        vectors++;
        if (run_cnt !== 8'd0) begin miscompares++; $display("FAIL glitch_run: got %0d want 0", run_cnt); end
        vectors++;
        step(4);
        if (C !== 3'b101) begin miscompares++; $display("FAIL glitch_e24: got %b want 101", C); end
        vectors++;
        step(4);
        if ({C, stable} !== 4'b0110) begin miscompares++; $display("FAIL glitch_e28: C,stable got %b want 0110", {C, stable}); end
        vectors++;
        step(4);
        if ({C, stable, level, run_cnt} !== {5'b11111, 8'd1}) begin miscompares++;
            $display("FAIL glitch_e32: C,stable,level=%b run=%0d want 11111 run=1", {C, stable, level}, run_cnt); end
        vectors++;
        if (fall_seen !== 1'b0) begin miscompares++; $display("FAIL glitch_fall: seen %b want 0", fall_seen); end
        vectors++;
    endtask

    // Starts on a tick edge with run_cnt=1.
    task automatic test_saturate;
        rise_seen = 1'b0; fall_seen = 1'b0;
        step(254 * 4);
        if (run_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_reach: got %0d want 255", run_cnt); end
        vectors++;
        step(46 * 4);
        if (run_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_hold: got %0d want 255", run_cnt); end
        vectors++;
        if ({rise_seen, fall_seen} !== 2'b00) begin miscompares++;
            $display("FAIL sat_pulses: rise,fall seen %b want 00", {rise_seen, fall_seen}); end
        vectors++;
        din = 1'b0;
        step(4);
        if ({C, run_cnt} !== {3'b110, 8'd0}) begin miscompares++; $display("FAIL drop_t1: C=%b run=%0d want 110 run=0", C, run_cnt); end
        vectors++;
        step(4);
        if (C !== 3'b100) begin miscompares++; $display("FAIL drop_t2: got %b want 100", C); end
        vectors++;
        step(3);
        if (level !== 1'b1) begin miscompares++; $display("FAIL drop_pre: level got %b want 1", level); end
        vectors++;
        step(1);
        if ({C, level, stable, fall, run_cnt} !== {3'b000, 3'b010, 8'd1}) begin miscompares++;
            $display("FAIL drop_t3: C=%b level,stable,fall=%b run=%0d want 000 010 run=1", C, {level, stable, fall}, run_cnt); end
        vectors++;
        step(1);
        if ({fall, rise} !== 2'b10) begin miscompares++; $display("FAIL fall_pulse: fall,rise got %b want 10", {fall, rise}); end
        vectors++;
        step(1);
        if (fall !== 1'b0) begin miscompares++; $display("FAIL fall_width: got %b want 0", fall); end
        vectors++;
    endtask

    task automatic test_en_drop;
        en = 1'b0; din = 1'b1;
        step(1);
        if ({valid, stable, run_cnt} !== 10'd0) begin miscompares++;
            $display("FAIL endrop_idle: valid,stable=%b run=%0d want 00 run=0", {valid, stable}, run_cnt); end
        vectors++;
        step(3);
        en = 1'b1;
        step(4);
        if ({C, valid} !== 4'b0010) begin miscompares++; $display("FAIL endrop_t1: C,valid got %b want 0010", {C, valid}); end
        vectors++;
        step(4);
        step(2);
        en = 1'b0;
        step(10);
        if ({C, valid} !== 4'b0110) begin miscompares++; $display("FAIL endrop_frozen: C,valid got %b want 0110", {C, valid}); end
        vectors++;
        en = 1'b1;
        step(3);
        if (C !== 3'b011) begin miscompares++; $display("FAIL endrop_pcnt: got %b want 011", C); end
        vectors++;
        step(1);
        if ({C, valid, stable} !== 5'b11100) begin miscompares++;
            $display("FAIL endrop_r1: C,valid,stable got %b want 11100", {C, valid, stable}); end
        vectors++;
        step(4);
        if (valid !== 1'b0) begin miscompares++; $display("FAIL endrop_r2: valid got %b want 0", valid); end
        vectors++;
        step(4);
        if ({valid, stable, level, run_cnt} !== {3'b111, 8'd1}) begin miscompares++;
            $display("FAIL endrop_r3: valid,stable,level=%b run=%0d want 111 run=1", {valid, stable, level}, run_cnt); end
        vectors++;
        step(1);
        if (rise !== 1'b1) begin miscompares++; $display("FAIL endrop_rise: got %b want 1", rise); end
        vectors++;
    endtask

    // Entered one edge after a tick; one more edge puts pcnt at 2.
    task automatic test_reset_mid;
        step(1);
        #2 reset = 1'b1;
        #1;
        if ({C, valid, stable, level, rise, fall} !== 8'd0) begin miscompares++;
            $display("FAIL rstmid_flags: got %b want 00000000", {C, valid, stable, level, rise, fall}); end
        vectors++;
        if (run_cnt !== 8'd0) begin miscompares++; $display("FAIL rstmid_run: got %0d want 0", run_cnt); end
        vectors++;
        step(2);
        test_fill("refill");
    endtask

    task automatic test_prescale1;
        reset = 1'b0; din1 = 1'b1; en1 = 1'b0;
        step(3);
        en1 = 1'b1;
        step(1);
        if ({C1, valid1} !== 4'b0010) begin miscompares++; $display("FAIL p1_e1: C,valid got %b want 0010", {C1, valid1}); end
        vectors++;
        step(1);
        if ({C1, valid1} !== 4'b0110) begin miscompares++; $display("FAIL p1_e2: C,valid got %b want 0110", {C1, valid1}); end
        vectors++;
        step(1);
        if ({C1, valid1, stable1, level1, rise1} !== 7'b1111110) begin miscompares++;
            $display("FAIL p1_e3: C,valid,stable,level,rise got %b want 1111110", {C1, valid1, stable1, level1, rise1}); end
        vectors++;
        if (run_cnt1 !== 8'd1) begin miscompares++; $display("FAIL p1_run: got %0d want 1", run_cnt1); end
        vectors++;
        step(1);
        if ({rise1, fall1} !== 2'b10) begin miscompares++; $display("FAIL p1_rise: rise,fall got %b want 10", {rise1, fall1}); end
        vectors++;
        step(1);
        if ({rise1, run_cnt1} !== {1'b0, 8'd3}) begin miscompares++;
            $display("FAIL p1_after: rise=%b run=%0d want 0 run=3", rise1, run_cnt1); end
        vectors++;
    endtask

    initial begin
        rise_seen = 1'b0;
        fall_seen = 1'b0;
        test_reset();
        test_fill("fill");
        test_glitch();
        test_saturate();
        test_en_drop();
        test_reset_mid();
        reset = 1'b1;
        step(1);
        test_prescale1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
